// File: rtl/text_pkg.sv
// Shared glyph codes, 8x16 font bitmap and start-screen message for the text overlay.
// Font rows are declared [0:7] so that index 0 is the leftmost pixel of a row.
package text_pkg;

    typedef enum logic [3:0] {
        GLY_SPACE = 4'd0,
        GLY_A     = 4'd1,
        GLY_E     = 4'd2,
        GLY_N     = 4'd3,
        GLY_O     = 4'd4,
        GLY_P     = 4'd5,
        GLY_R     = 4'd6,
        GLY_S     = 4'd7,
        GLY_T     = 4'd8
    } glyph_t;

    typedef enum logic [1:0] {
        MODE_STEADY     = 2'd0,
        MODE_BLINK      = 2'd1,
        MODE_TYPE       = 2'd2,
        MODE_STEADY_ALT = 2'd3
    } mode_t;

    typedef logic [0:7] font_row_t;

    // Codes 9..15 are spares and stay blank.
    localparam font_row_t FONT [16][16] = '{
        '{default: 8'h00},
        '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFE, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFC, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFE, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hC6, 8'hE6, 8'hE6, 8'hF6, 8'hF6, 8'hDE, 8'hDE, 8'hCE, 8'hCE, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFC, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hFC, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFC, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hFC, 8'hD8, 8'hCC, 8'hCC, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC0, 8'hC0, 8'h60, 8'h38, 8'h0C, 8'h06, 8'h06, 8'h06, 8'hC6, 8'h7C, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'hFE, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h00},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00},
        '{default: 8'h00}
    };

    localparam int MSG_LEN = 20;

    // "PRESS ENTER TO START"
    localparam glyph_t DEFAULT_MSG [MSG_LEN] = '{
        GLY_P, GLY_R, GLY_E, GLY_S, GLY_S, GLY_SPACE,
        GLY_E, GLY_N, GLY_T, GLY_E, GLY_R, GLY_SPACE,
        GLY_T, GLY_O, GLY_SPACE,
        GLY_S, GLY_T, GLY_A, GLY_R, GLY_T
    };

    function automatic glyph_t init_glyph(input int idx);
        if (idx < MSG_LEN) begin
            return DEFAULT_MSG[idx];
        end
        return GLY_SPACE;
    endfunction

    function automatic logic font_pixel(input logic [3:0] code, input logic [3:0] gy,
                                        input logic [2:0] gx);
        return FONT[code][gy][gx];
    endfunction

endpackage

// File: rtl/text_anim_ctrl.sv
// Frame-rate animation state for the text overlay: blink phase and typewriter reveal count.
// Any mode change, or enable low, restarts the animation on the next clock.
module text_anim_ctrl
    import text_pkg::*;
#(
    parameter int COLS          = 20,
    parameter int BLINK_FRAMES  = 30,
    parameter int REVEAL_FRAMES = 4,
    localparam int RW = $clog2(COLS + 1)
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic          frame_start,
    output logic          phase_on,
    output logic [RW-1:0] reveal_cnt,
    output logic          reveal_done
);

    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam int FW = $clog2(REVEAL_FRAMES + 1);

    logic [1:0]    mode_reg;
    logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
    logic          phase_on_reg, phase_on_next;
    logic [FW-1:0] frame_cnt_reg, frame_cnt_next;
    logic [RW-1:0] reveal_cnt_reg, reveal_cnt_next;
    logic          reveal_done_reg, reveal_done_next;
    logic          restart;

    assign restart = !enable || (mode != mode_reg);

    always_comb begin
        blink_cnt_next  = blink_cnt_reg;
        phase_on_next   = phase_on_reg;
        frame_cnt_next  = frame_cnt_reg;
        reveal_cnt_next = reveal_cnt_reg;
        if (restart) begin
            // A frame_start coinciding with the restart is deliberately dropped.
            blink_cnt_next  = '0;
            phase_on_next   = 1'b1;
            frame_cnt_next  = '0;
            reveal_cnt_next = '0;
        end else if (frame_start) begin
            if (mode == MODE_BLINK) begin
                if (blink_cnt_reg == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_next = '0;
                    phase_on_next  = !phase_on_reg;
                end else begin
                    blink_cnt_next = blink_cnt_reg + 1'b1;
                end
            end
            if (mode == MODE_TYPE) begin
                if (frame_cnt_reg == FW'(REVEAL_FRAMES - 1)) begin
                    frame_cnt_next = '0;
                    if (reveal_cnt_reg < RW'(COLS)) begin
                        reveal_cnt_next = reveal_cnt_reg + 1'b1;
                    end
                end else begin
                    frame_cnt_next = frame_cnt_reg + 1'b1;
                end
            end
        end
        reveal_done_next = (reveal_cnt_next == RW'(COLS));
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            mode_reg        <= MODE_STEADY;
            blink_cnt_reg   <= '0;
            phase_on_reg    <= 1'b1;
            frame_cnt_reg   <= '0;
            reveal_cnt_reg  <= '0;
            reveal_done_reg <= 1'b0;
        end else begin
            mode_reg        <= mode;
            blink_cnt_reg   <= blink_cnt_next;
            phase_on_reg    <= phase_on_next;
            frame_cnt_reg   <= frame_cnt_next;
            reveal_cnt_reg  <= reveal_cnt_next;
            reveal_done_reg <= reveal_done_next;
        end
    end

    assign phase_on    = phase_on_reg;
    assign reveal_cnt  = reveal_cnt_reg;
    assign reveal_done = reveal_done_reg;

endmodule

// File: rtl/text_overlay_engine.sv
// Single-line text overlay: writable glyph buffer, 8x16 font lookup with integer scaling,
// two-stage pipeline from DrawX/DrawY to the registered text_active mask.
module text_overlay_engine
    import text_pkg::*;
#(
    parameter int COLS          = 20,
    parameter int X0            = 244,
    parameter int Y0            = 360,
    parameter int SCALE_LOG2    = 0,
    parameter int BLINK_FRAMES  = 30,
    parameter int REVEAL_FRAMES = 4,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic          frame_start,
    input  logic          enable,
    input  logic [1:0]    mode,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_addr,
    input  logic [3:0]    wr_char,
    output logic          text_active,
    output logic          reveal_done
);

    localparam int RW    = $clog2(COLS + 1);
    localparam int BOX_W = (COLS * 8) << SCALE_LOG2;
    localparam int BOX_H = 16 << SCALE_LOG2;

    localparam logic [10:0] X_ORG = 11'(X0);
    localparam logic [10:0] Y_ORG = 11'(Y0);
    localparam logic [10:0] W_LIM = 11'(BOX_W);
    localparam logic [10:0] H_LIM = 11'(BOX_H);

    // ---------------- character buffer ----------------
    logic [3:0] char_buf [COLS];

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_buf
            localparam logic [3:0] INIT_CODE = init_glyph(gi);
            logic [3:0] glyph_reg;

            always_ff @(posedge CLK) begin
                if (RESET) begin
                    glyph_reg <= INIT_CODE;
                end else if (wr_en && (wr_addr == CW'(gi))) begin
                    glyph_reg <= wr_char;
                end
            end

            assign char_buf[gi] = glyph_reg;
        end
    endgenerate

    // ---------------- animation control ----------------
    logic          phase_on;
    logic [RW-1:0] reveal_cnt;

    text_anim_ctrl #(
        .COLS          (COLS),
        .BLINK_FRAMES  (BLINK_FRAMES),
        .REVEAL_FRAMES (REVEAL_FRAMES)
    ) u_anim (
        .clk         (CLK),
        .srst        (RESET),
        .enable      (enable),
        .mode        (mode),
        .frame_start (frame_start),
        .phase_on    (phase_on),
        .reveal_cnt  (reveal_cnt),
        .reveal_done (reveal_done)
    );

    // ---------------- stage 1: box decode and buffer read ----------------
    logic [10:0] x_ext, y_ext, dx, dy, col_w;
    logic        inside_next, vis_next;
    logic [2:0]  gx_next;
    logic [3:0]  gy_next;
    logic [3:0]  code_next;

    assign x_ext = {1'b0, DrawX};
    assign y_ext = {1'b0, DrawY};
    assign dx    = x_ext - X_ORG;
    assign dy    = y_ext - Y_ORG;
    assign col_w = dx >> (3 + SCALE_LOG2);

    // dx/dy wrap to large values left of / above the box, hence the explicit origin tests.
    assign inside_next = enable && (x_ext >= X_ORG) && (dx < W_LIM)
                                && (y_ext >= Y_ORG) && (dy < H_LIM);
    assign gx_next     = dx[SCALE_LOG2 +: 3];
    assign gy_next     = dy[SCALE_LOG2 +: 4];
    assign code_next   = (col_w < 11'(COLS)) ? char_buf[col_w[CW-1:0]] : GLY_SPACE;

    always_comb begin
        vis_next = 1'b1;
        case (mode)
            MODE_BLINK: vis_next = phase_on;
            MODE_TYPE:  vis_next = (col_w < 11'(reveal_cnt));
            default:    vis_next = 1'b1;
        endcase
    end

    logic       inside_reg, vis_reg;
    logic [2:0] gx_reg;
    logic [3:0] gy_reg;
    logic [3:0] code_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            inside_reg <= 1'b0;
            vis_reg    <= 1'b0;
            gx_reg     <= '0;
            gy_reg     <= '0;
            code_reg   <= GLY_SPACE;
        end else begin
            inside_reg <= inside_next;
            vis_reg    <= vis_next;
            gx_reg     <= gx_next;
            gy_reg     <= gy_next;
            code_reg   <= code_next;
        end
    end

    // ---------------- stage 2: font lookup ----------------
    logic text_active_reg;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            text_active_reg <= 1'b0;
        end else begin
            text_active_reg <= inside_reg && vis_reg && font_pixel(code_reg, gy_reg, gx_reg);
        end
    end

    assign text_active = text_active_reg;

endmodule

// File: tb/tb_text_overlay_engine.sv
// Directed bench for text_overlay_engine: one unscaled instance with short animation
// periods and one 2x-scaled instance sharing the same stimulus.
module tb_text_overlay_engine;
    import text_pkg::*;

    logic       clk = 1'b0;
    logic       RESET;
    logic [9:0] DrawX, DrawY;
    logic       frame_start, enable;
    logic [1:0] mode;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [3:0] wr_char;
    logic       ta0, rd0, ta1, rd1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    text_overlay_engine #(
        .COLS(20), .X0(244), .Y0(360), .SCALE_LOG2(0), .BLINK_FRAMES(2), .REVEAL_FRAMES(1)
    ) dut0 (
        .CLK(clk), .RESET(RESET), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .enable(enable), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .text_active(ta0), .reveal_done(rd0)
    );

    text_overlay_engine #(
        .COLS(20), .X0(244), .Y0(360), .SCALE_LOG2(1), .BLINK_FRAMES(30), .REVEAL_FRAMES(4)
    ) dut1 (
        .CLK(clk), .RESET(RESET), .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
        .enable(enable), .mode(mode), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .text_active(ta1), .reveal_done(rd1)
    );

    // Bench-side reference message and glyph numbering.
    string ref_msg = "PRESS ENTER TO START";

    function automatic logic [3:0] ref_glyph(input byte c);
        case (c)
            "A": return 4'd1;
            "E": return 4'd2;
            "N": return 4'd3;
            "O": return 4'd4;
            "P": return 4'd5;
            "R": return 4'd6;
            "S": return 4'd7;
            "T": return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic ref_pixel(input int x, input int y);
        int col;
        logic [3:0] g;
        if (x < 244 || x >= 404 || y < 360 || y >= 376) return 1'b0;
        col = (x - 244) / 8;
        g   = ref_glyph(ref_msg[col]);
        return FONT[g][y - 360][(x - 244) % 8];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp, input bit verbose);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
        end
        if (verbose) $display("%s: observed %0b expected %0b", tag, obs, exp);
    endtask

    task automatic probe(input int x, input int y, output logic v0, output logic v1);
        @(negedge clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge clk);
        @(posedge clk);
        #1;
        v0 = ta0;
        v1 = ta1;
    endtask

    task automatic pulse_frame();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic v0, v1;
        int   row_err;

        RESET = 1'b1; DrawX = '0; DrawY = '0; frame_start = 1'b0; enable = 1'b1;
        mode = 2'd0; wr_en = 1'b0; wr_addr = '0; wr_char = '0;
        repeat (3) @(negedge clk);
        check("reset text_active dut0", ta0, 1'b0, 1);
        check("reset reveal_done dut0", rd0, 1'b0, 1);
        check("reset text_active dut1", ta1, 1'b0, 1);
        check("reset reveal_done dut1", rd1, 1'b0, 1);
        RESET = 1'b0;
        repeat (2) @(negedge clk);

        // Steady scan of the box with a margin on every side.
        for (int y = 358; y < 378; y++) begin
            row_err = n_fail;
            for (int x = 240; x < 408; x++) begin
                probe(x, y, v0, v1);
                check($sformatf("scan(%0d,%0d)", x, y), v0, ref_pixel(x, y), 0);
            end
            $display("scan row y=%0d: %0d pixel errors", y, n_fail - row_err);
        end
        probe(244, 362, v0, v1); check("pix(244,362)", v0, 1'b1, 1);
        probe(243, 362, v0, v1); check("pix(243,362)", v0, 1'b0, 1);

        // Single-cycle pixel: exactly 2 cycles latency, 1 cycle wide.
        @(negedge clk); DrawX = 10'd0; DrawY = 10'd0;
        repeat (3) @(negedge clk);
        DrawX = 10'd244; DrawY = 10'd362;
        @(negedge clk); DrawX = 10'd0; DrawY = 10'd0;
        check("latency +1", ta0, 1'b0, 1);
        @(negedge clk); check("latency +2", ta0, 1'b1, 1);
        @(negedge clk); check("latency +3", ta0, 1'b0, 1);

        // enable low blanks the output.
        @(negedge clk); enable = 1'b0;
        probe(244, 362, v0, v1); check("enable=0 blank", v0, 1'b0, 1);
        @(negedge clk); enable = 1'b1;

        // Blink, BLINK_FRAMES=2: visible for two frames, blank for two.
        @(negedge clk); mode = 2'd1;
        repeat (2) @(negedge clk);
        for (int n = 0; n <= 8; n++) begin
            probe(244, 362, v0, v1);
            check($sformatf("blink frame %0d", n), v0, ((n / 2) % 2) == 0, 1);
            pulse_frame();
        end

        // Typewriter, REVEAL_FRAMES=1: one column per frame.
        @(negedge clk); mode = 2'd2;
        repeat (2) @(negedge clk);
        probe(244, 362, v0, v1); check("type 0 frames col0", v0, 1'b0, 1);
        repeat (3) pulse_frame();
        probe(244, 362, v0, v1); check("type 3 frames col0", v0, 1'b1, 1);
        probe(260, 362, v0, v1); check("type 3 frames col2", v0, 1'b1, 1);
        probe(269, 362, v0, v1); check("type 3 frames col3", v0, 1'b0, 1);
        repeat (16) pulse_frame();
        check("reveal_done after 19", rd0, 1'b0, 1);
        probe(396, 362, v0, v1); check("type 19 frames col19", v0, 1'b0, 1);
        pulse_frame();
        check("reveal_done after 20", rd0, 1'b1, 1);
        probe(396, 362, v0, v1); check("type 20 frames col19", v0, 1'b1, 1);
        repeat (5) pulse_frame();
        check("reveal_done after 25", rd0, 1'b1, 1);
        @(negedge clk); mode = 2'd0;
        @(posedge clk); #1;
        check("reveal_done drop on mode change", rd0, 1'b0, 1);
        @(negedge clk); mode = 2'd2;
        repeat (2) @(negedge clk);
        check("reveal_done after re-entry", rd0, 1'b0, 1);
        probe(244, 362, v0, v1); check("type re-entry col0", v0, 1'b0, 1);
        @(negedge clk); mode = 2'd0;
        repeat (2) @(negedge clk);

        // Scaled instance: 320x32 box.
        probe(244, 364, v0, v1); check("x2 (244,364)", v1, 1'b1, 1);
        probe(245, 365, v0, v1); check("x2 (245,365)", v1, 1'b1, 1);
        probe(246, 368, v0, v1); check("x2 (246,368)", v1, 1'b1, 1);
        probe(248, 368, v0, v1); check("x2 (248,368)", v1, 1'b0, 1);
        probe(245, 386, v0, v1); check("x2 (245,386)", v1, 1'b1, 1);
        probe(560, 364, v0, v1); check("x2 (560,364)", v1, 1'b1, 1);
        probe(562, 364, v0, v1); check("x2 (562,364)", v1, 1'b0, 1);
        probe(564, 360, v0, v1); check("x2 (564,360)", v1, 1'b0, 1);
        probe(564, 364, v0, v1); check("x2 (564,364)", v1, 1'b0, 1);

        // Write col0 <- T in the same cycle its pixel is read.
        @(negedge clk);
        DrawX = 10'd244; DrawY = 10'd363;
        wr_en = 1'b1; wr_addr = 5'd0; wr_char = 4'd8;
        @(negedge clk); wr_en = 1'b0;
        @(negedge clk); check("write same cycle old glyph", ta0, 1'b1, 1);
        @(negedge clk); check("write next cycle new glyph", ta0, 1'b0, 1);
        probe(247, 363, v0, v1); check("written T (247,363)", v0, 1'b1, 1);
        @(negedge clk); wr_en = 1'b1; wr_addr = 5'd25; wr_char = 4'd8;
        @(negedge clk); wr_en = 1'b0;
        probe(284, 362, v0, v1); check("oob write col5", v0, 1'b0, 1);
        probe(319, 363, v0, v1); check("oob write col9 bit3", v0, 1'b0, 1);
        probe(316, 363, v0, v1); check("oob write col9 bit0", v0, 1'b1, 1);

        // Reset mid-scan over a lit pixel.
        probe(244, 362, v0, v1); check("pre-reset lit", v0, 1'b1, 1);
        @(negedge clk); RESET = 1'b1;
        @(posedge clk); #1; check("reset clears next edge", ta0, 1'b0, 1);
        @(negedge clk); RESET = 1'b0;
        @(posedge clk); #1; check("post-reset +1", ta0, 1'b0, 1);
        @(posedge clk); #1; check("post-reset +2", ta0, 1'b1, 1);
        probe(244, 363, v0, v1); check("reset reloads P", v0, 1'b1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
